dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 43 ++++
 rtl/dmem_lane_align.sv | 44 ++++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and encodings for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  // RV32I load/store funct3 codes
  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  // Access size lives in funct3[1:0]; funct3[2] selects zero-extension on loads
  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [1:0] ErrNone       = 2'b00;
  localparam logic [1:0] ErrMisaligned = 2'b01;
  localparam logic [1:0] ErrTimeout    = 2'b10;
  localparam logic [1:0] ErrIllegal    = 2'b11;

  // Classify a request before any memory access is started
  function automatic logic [1:0] req_check(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [1:0] err;
    err = ErrNone;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
      err = ErrIllegal;
    end else if ((funct3[1:0] == SizeHalf && addr_lo[0]) ||
                 (funct3[1:0] == SizeWord && addr_lo != 2'b00)) begin
      err = ErrMisaligned;
    end
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mode replicates data and builds byte enables,
// load mode picks the addressed byte/half and extends it.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter bit StoreMode = 1'b0
) (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  be_o
);

  logic [31:0] shifted;
  logic        zext;

  assign shifted = data_i >> {addr_lo_i, 3'b000};
  assign zext    = funct3_i[2];

  // Size decode drives both lane enables and the steered data word
  always_comb begin
    be_o   = 4'b0000;
    data_o = 32'h0;
    case (funct3_i[1:0])
      SizeByte: begin
        be_o = 4'b0001 << addr_lo_i;
        if (StoreMode) data_o = {4{data_i[7:0]}};
        else           data_o = {{24{~zext & shifted[7]}}, shifted[7:0]};
      end
      SizeHalf: begin
        be_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        if (StoreMode) data_o = {2{data_i[15:0]}};
        else           data_o = {{16{~zext & shifted[15]}}, shifted[15:0]};
      end
      SizeWord: begin
        be_o   = 4'b1111;
        data_o = data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: accepts one request, runs a bounded
// memory handshake and reports a one-cycle completion with data or error.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        DoneM,
  output logic        StallMem,
  output logic        ErrM,
  output logic [1:0]  ErrCause,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      err_q, err_d;

  logic [1:0]  req_err;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;
  logic [3:0]  unused_ld_be;

  assign req_err = req_check(funct3M, ALUResultM[1:0]);

  dmem_lane_align #(
    .StoreMode(1'b1)
  ) u_store_align (
    .funct3_i (funct3M),
    .addr_lo_i(ALUResultM[1:0]),
    .data_i   (WriteDataM),
    .data_o   (st_wdata),
    .be_o     (st_be)
  );

  dmem_lane_align #(
    .StoreMode(1'b0)
  ) u_load_align (
    .funct3_i (f3_q),
    .addr_lo_i(addr_q[1:0]),
    .data_i   (rdata_q),
    .data_o   (ld_data),
    .be_o     (unused_ld_be)
  );

  // Next-state: latch on accept, wait for ready or timeout, then report
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (MemReqM) begin
          addr_d  = ALUResultM;
          f3_d    = funct3M;
          we_d    = MemWriteM;
          be_d    = st_be;
          wdata_d = st_wdata;
          rdata_d = 32'h0;
          cnt_d   = '0;
          err_d   = req_err;
          // Bad requests skip the memory entirely
          state_d = (req_err == ErrNone) ? StAccess : StDone;
        end
      end
      StAccess: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = StDone;
        end else if (cnt_q == CntLast) begin
          err_d   = ErrTimeout;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and transaction registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      f3_q    <= 3'b000;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= ErrNone;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from state; results are only presented in DONE
  always_comb begin
    DoneM     = (state_q == StDone);
    StallMem  = ((state_q == StIdle) && MemReqM) || (state_q == StAccess);
    ErrM      = DoneM && (err_q != ErrNone);
    ErrCause  = DoneM ? err_q : ErrNone;
    ReadDataM = (DoneM && err_q == ErrNone && !we_q) ? ld_data : 32'h0;
    mem_en    = (state_q == StAccess);
    mem_we    = mem_en && we_q;
    mem_be    = mem_en ? be_q : 4'b0000;
    mem_addr  = addr_q[31:2];
    mem_wdata = wdata_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder with a transaction-level reference model.
module tb_dmem_responder;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReqM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        DoneM, StallMem, ErrM;
  logic [1:0]  ErrCause;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  // Expected outputs for the current cycle
  logic        chk_en, e_rsts;
  logic        e_stall, e_en, e_we, e_done;
  logic [3:0]  e_be;
  logic [29:0] e_addr;
  logic [31:0] e_wd, e_rd;
  logic [1:0]  e_cause;

  // Hand-computed literals for the directed cases
  logic        lit_acc, lit_done;
  logic [29:0] lit_addr;
  logic [3:0]  lit_be;
  logic [31:0] lit_wd, lit_rd;
  logic [1:0]  lit_cause;

  dmem_responder #(
    .TIMEOUT(TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .MemReqM   (MemReqM),
    .MemWriteM (MemWriteM),
    .funct3M   (funct3M),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .ReadDataM (ReadDataM),
    .DoneM     (DoneM),
    .StallMem  (StallMem),
    .ErrM      (ErrM),
    .ErrCause  (ErrCause),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  function automatic logic [1:0] m_cause(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 2'b11;
    if ((f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'd0) return 4'(1 << a[1:0]);
    if (f3[1:0] == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'd0) return {4{d[7:0]}};
    if (f3[1:0] == 2'd1) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] d);
    logic [31:0] s;
    s = d >> (int'(a[1:0]) * 8);
    if (f3 == 3'd0) return {{24{s[7]}}, s[7:0]};
    if (f3 == 3'd4) return {24'h0, s[7:0]};
    if (f3 == 3'd1) return {{16{s[15]}}, s[15:0]};
    if (f3 == 3'd5) return {16'h0, s[15:0]};
    return d;
  endfunction

  // Single compare process, sampled mid-low-phase
  always @(negedge clk) begin
    #3;
    if (chk_en) begin
      chk("StallMem", 32'(StallMem), 32'(e_stall));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("DoneM", 32'(DoneM), 32'(e_done));
      if (e_en || e_rsts) chk("mem_we", 32'(mem_we), 32'(e_we));
      if ((e_en && e_we) || e_rsts) chk("mem_be", 32'(mem_be), 32'(e_be));
      if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      if (e_en && e_we) chk("mem_wdata", mem_wdata, e_wd);
      if (e_done || e_rsts) begin
        chk("ReadDataM", ReadDataM, e_rd);
        chk("ErrM", 32'(ErrM), 32'(e_cause != 2'b00));
        chk("ErrCause", 32'(ErrCause), 32'(e_cause));
      end
      if (lit_acc && e_en) begin
        chk("lit_addr", 32'(mem_addr), 32'(lit_addr));
        if (e_we) begin
          chk("lit_be", 32'(mem_be), 32'(lit_be));
          chk("lit_wdata", mem_wdata, lit_wd);
          chk("lit_we", 32'(mem_we), 32'd1);
        end
      end
      if (lit_done && e_done) begin
        chk("lit_rdata", ReadDataM, lit_rd);
        chk("lit_cause", 32'(ErrCause), 32'(lit_cause));
      end
    end
  end

  task automatic set_exp(input logic stall, input logic en, input logic we, input logic [3:0] be,
                         input logic [29:0] addr, input logic [31:0] wd, input logic done,
                         input logic [1:0] cause, input logic [31:0] rd);
    e_stall = stall;
    e_en    = en;
    e_we    = we;
    e_be    = be;
    e_addr  = addr;
    e_wd    = wd;
    e_done  = done;
    e_cause = cause;
    e_rd    = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      MemReqM    = 1'b0;
      ALUResultM = $urandom;
      mem_ready  = 1'($urandom);
      mem_rdata  = $urandom;
      set_exp(1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 2'b00, 32'h0);
      @(negedge clk);
    end
  endtask

  // One request from acceptance through DONE; called and returns at a negedge
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int waits);
    logic [1:0]  cause;
    logic [31:0] rexp;
    int          n_acc;
    cause = m_cause(f3, addr);
    if (cause != 2'b00) begin
      n_acc = 0;
    end else if (waits < int'(TO)) begin
      n_acc = waits + 1;
    end else begin
      n_acc = int'(TO);
      cause = 2'b10;
    end
    rexp = (cause != 2'b00 || we) ? 32'h0 : m_rd(f3, addr, rd);

    MemReqM    = 1'b1;
    MemWriteM  = we;
    funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    mem_ready  = 1'($urandom);
    mem_rdata  = $urandom;
    set_exp(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    for (int k = 1; k <= n_acc; k++) begin
      mem_ready = (k == waits + 1);
      mem_rdata = mem_ready ? rd : $urandom;
      set_exp(1'b1, 1'b1, we, m_be(f3, addr), addr[31:2], m_wd(f3, wd), 1'b0, 2'b00, 32'h0);
      @(negedge clk);
    end
    // A request shown during DONE must not be taken
    MemReqM    = 1'b1;
    MemWriteM  = 1'($urandom);
    funct3M    = 3'($urandom);
    ALUResultM = $urandom;
    WriteDataM = $urandom;
    mem_ready  = 1'($urandom);
    mem_rdata  = $urandom;
    set_exp(1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b1, cause, rexp);
    @(negedge clk);
    MemReqM   = 1'b0;
    mem_ready = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 2'b00, 32'h0);
  endtask

  initial begin
    logic [2:0]  st_codes [6];
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;

    st_codes = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
    rst = 1'b1;
    MemReqM = 1'b0; MemWriteM = 1'b0; funct3M = 3'd0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    chk_en = 1'b0; e_rsts = 1'b0; lit_acc = 1'b0; lit_done = 1'b0;
    lit_addr = 30'h0; lit_be = 4'h0; lit_wd = 32'h0; lit_rd = 32'h0; lit_cause = 2'b00;
    set_exp(1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 2'b00, 32'h0);

    // Reset values, checked after the first reset edge
    @(negedge clk);
    chk_en = 1'b1;
    e_rsts = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    e_rsts = 1'b0;
    idle(2);

    // lw, zero-wait
    lit_acc = 1'b1; lit_addr = 30'h40;
    lit_done = 1'b1; lit_rd = 32'hDEADBEEF; lit_cause = 2'b00;
    run_txn(1'b0, 3'd2, 32'h100, $urandom, 32'hDEADBEEF, 0);
    lit_acc = 1'b0;

    // lb / lbu on top byte
    lit_rd = 32'hFFFFFF80;
    run_txn(1'b0, 3'd0, 32'h103, $urandom, 32'h80FF_FFFF, 0);
    lit_rd = 32'h00000080;
    run_txn(1'b0, 3'd4, 32'h103, $urandom, 32'h80FF_FFFF, 1);

    // sh upper half with three wait cycles
    lit_acc = 1'b1; lit_addr = 30'h80; lit_be = 4'b1100; lit_wd = 32'hABCDABCD;
    lit_rd = 32'h0;
    run_txn(1'b1, 3'd1, 32'h202, 32'h1234ABCD, $urandom, 3);
    lit_acc = 1'b0;

    // Misaligned lw
    lit_cause = 2'b01;
    run_txn(1'b0, 3'd2, 32'h101, $urandom, $urandom, 0);

    // Timeout
    lit_cause = 2'b10;
    run_txn(1'b0, 3'd2, 32'h104, $urandom, $urandom, 10);
    lit_done = 1'b0;
    idle(1);

    // Reset in the second ACCESS cycle
    MemReqM = 1'b1; MemWriteM = 1'b0; funct3M = 3'd2; ALUResultM = 32'h300;
    mem_ready = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    set_exp(1'b1, 1'b1, 1'b0, 4'hF, 30'hC0, 32'h0, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    MemReqM = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, 4'h0, 30'h0, 32'h0, 1'b0, 2'b00, 32'h0);
    @(negedge clk);
    idle(3);
    lit_done = 1'b1; lit_rd = 32'h13579BDF; lit_cause = 2'b00;
    run_txn(1'b0, 3'd2, 32'h300, $urandom, 32'h13579BDF, 1);
    lit_done = 1'b0;

    // Random traffic, some back-to-back
    repeat (400) begin
      we   = 1'($urandom);
      f3   = we ? st_codes[$urandom_range(0, 5)] : 3'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      run_txn(we, f3, addr, $urandom, $urandom, $urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
